count_extender: RTL and testbench

//  Downstream companion of the 4-bit universal counter. It watches the counter's digit and its controls
//  (clear/pause/incr/mode) on the same clock edge, and propagates carries and borrows into NUM_HI higher

---
 rtl/count_pkg.sv | 68 ++++++
 rtl/seg7_scan.sv | 45 ++++
 rtl/count_extender.sv | 89 ++++++++
 tb/tb_count_extender.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// Shared radix constants, 7-segment glyphs and digit helpers for the counter
// extension chain and its display scanner.
package count_pkg;

    typedef enum logic {
        RADIX_HEX = 1'b0,
        RADIX_DEC = 1'b1
    } radix_e;

    localparam logic [3:0] RADIX_DEC_TOP = 4'd9;
    localparam logic [3:0] RADIX_HEX_TOP = 4'd15;

    // Glyphs are packed {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [3:0] digit_top(input logic mode);
        return (radix_e'(mode) == RADIX_DEC) ? RADIX_DEC_TOP : RADIX_HEX_TOP;
    endfunction

    // Out-of-range digits (left over from hex mode) land on a legal value on their first step.
    function automatic logic [3:0] digit_step(input logic [3:0] d, input logic up, input logic [3:0] top);
        if (up) begin
            return (d >= top) ? 4'd0 : d + 4'd1;
        end
        return (d == 4'd0 || d > top) ? top : d - 4'd1;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] value, input logic mode);
        if (radix_e'(mode) == RADIX_DEC && value > RADIX_DEC_TOP) begin
            return SEG_BLANK;
        end
        case (value)
            4'h0: return SEG_0;
            4'h1: return SEG_1;
            4'h2: return SEG_2;
            4'h3: return SEG_3;
            4'h4: return SEG_4;
            4'h5: return SEG_5;
            4'h6: return SEG_6;
            4'h7: return SEG_7;
            4'h8: return SEG_8;
            4'h9: return SEG_9;
            4'hA: return SEG_A;
            4'hB: return SEG_B;
            4'hC: return SEG_C;
            4'hD: return SEG_D;
            4'hE: return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/seg7_scan.sv
// Time-multiplexes a flat bus of 4-bit digits onto one 7-segment output,
// holding each digit for SCAN_DIV clocks.
module seg7_scan
    import count_pkg::*;
#(
    parameter int NUM_DIG  = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4*NUM_DIG-1:0] digits,
    input  logic                 mode,
    output logic [NUM_DIG-1:0]   an,
    output logic [6:0]           seg
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIG - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [IDX_W-1:0] idx;
    logic [3:0]       sel_digit;

    assign sel_digit = digits[4*idx +: 4];

    // idx names the slot lit on the next terminal count, so slot 0 is the first one shown after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            idx     <= '0;
            an      <= '0;
            seg     <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            an      <= NUM_DIG'(1) << idx;
            seg     <= seg_decode(sel_digit, mode);
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/count_extender.sv
// Extends the 4-bit universal counter with NUM_HI higher digits of the same radix
// and scans all digits onto a single 7-segment display.
module count_extender
    import count_pkg::*;
#(
    parameter int NUM_HI   = 3,
    parameter int SCAN_DIV = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          count,
    input  logic                mode,
    input  logic                clear,
    input  logic                incr,
    input  logic                pause,
    output logic [4*NUM_HI-1:0] digits_hi,
    output logic                carry_out,
    output logic                ovf,
    output logic [NUM_HI:0]     an,
    output logic [6:0]          seg
);

    logic [3:0]          radix_top;
    logic                carry0;
    logic                top_carry;
    logic [4*NUM_HI-1:0] digits_q;
    logic [4*NUM_HI-1:0] digits_next;

    assign radix_top = digit_top(mode);

    // Counter digit is sampled pre-edge, so the carry lands as the counter itself wraps.
    assign carry0 = incr ? (count == radix_top) : (count == 4'd0);

    genvar k;
    generate
        for (k = 0; k < NUM_HI; k++) begin : g_stage
            logic       cin;
            logic       cout;
            logic [3:0] d;

            if (k == 0) begin : g_first
                assign cin = carry0;
            end else begin : g_rest
                assign cin = g_stage[k-1].cout;
            end

            assign d    = digits_q[4*k +: 4];
            assign cout = cin & (incr ? (d == radix_top) : (d == 4'd0));
            assign digits_next[4*k +: 4] = cin ? digit_step(d, incr, radix_top) : d;
        end
    endgenerate

    assign top_carry = g_stage[NUM_HI-1].cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q  <= '0;
            carry_out <= 1'b0;
            ovf       <= 1'b0;
        end else if (clear) begin
            digits_q  <= '0;
            carry_out <= 1'b0;
            ovf       <= 1'b0;
        end else if (pause) begin
            carry_out <= 1'b0;
        end else begin
            digits_q  <= digits_next;
            carry_out <= top_carry;
            if (top_carry) begin
                ovf <= 1'b1;
            end
        end
    end

    assign digits_hi = digits_q;

    seg7_scan #(
        .NUM_DIG  (NUM_HI + 1),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk    (clk),
        .rst_n  (rst_n),
        .digits ({digits_q, count}),
        .mode   (mode),
        .an     (an),
        .seg    (seg)
    );

endmodule

// File: tb/tb_count_extender.sv
// Self-checking bench for count_extender: the extension digits are modelled as one
// integer in the active radix, the scanner as a slot schedule since reset release.
module tb_count_extender;

    localparam int NUM_HI   = 3;
    localparam int SCAN_DIV = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [3:0]          count;
    logic                mode;
    logic                clear;
    logic                incr;
    logic                pause;
    logic [4*NUM_HI-1:0] digits_hi;
    logic                carry_out;
    logic                ovf;
    logic [NUM_HI:0]     an;
    logic [6:0]          seg;

    int checks = 0;
    int errors = 0;
    int ext_val;
    bit m_ovf;
    bit m_carry;
    int cyc;
    bit saw_carry;

    count_extender #(
        .NUM_HI   (NUM_HI),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .count     (count),
        .mode      (mode),
        .clear     (clear),
        .incr      (incr),
        .pause     (pause),
        .digits_hi (digits_hi),
        .carry_out (carry_out),
        .ovf       (ovf),
        .an        (an),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [6:0] glyph(input int v, input bit dec);
        if (dec && v > 9) return 7'h00;
        case (v)
            0:  return 7'h3F;
            1:  return 7'h06;
            2:  return 7'h5B;
            3:  return 7'h4F;
            4:  return 7'h66;
            5:  return 7'h6D;
            6:  return 7'h7D;
            7:  return 7'h07;
            8:  return 7'h7F;
            9:  return 7'h6F;
            10: return 7'h77;
            11: return 7'h7C;
            12: return 7'h39;
            13: return 7'h5E;
            14: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    function automatic logic [4*NUM_HI-1:0] to_digits(input int v, input bit dec);
        logic [4*NUM_HI-1:0] out;
        int r;
        int rem;
        r   = dec ? 10 : 16;
        rem = v;
        out = '0;
        for (int k = 0; k < NUM_HI; k++) begin
            out[4*k +: 4] = 4'(rem % r);
            rem = rem / r;
        end
        return out;
    endfunction

    // The extension is a single number modulo radix**NUM_HI that moves by one on a counter wrap.
    task automatic modelEdge(input int cnt);
        int r;
        int top;
        int m;
        r   = mode ? 10 : 16;
        top = r - 1;
        m   = r ** NUM_HI;
        if (clear) begin
            ext_val = 0;
            m_ovf   = 1'b0;
            m_carry = 1'b0;
        end else if (pause) begin
            m_carry = 1'b0;
        end else begin
            m_carry = 1'b0;
            if (incr && cnt == top) begin
                ext_val = ext_val + 1;
                if (ext_val == m) begin
                    ext_val = 0;
                    m_carry = 1'b1;
                end
            end else if (!incr && cnt == 0) begin
                if (ext_val == 0) begin
                    ext_val = m - 1;
                    m_carry = 1'b1;
                end else begin
                    ext_val = ext_val - 1;
                end
            end
            if (m_carry) m_ovf = 1'b1;
        end
    endtask

    task automatic applyStimulus(input logic c, input logic p, input logic i, input logic md, input int cnt);
        clear = c;
        pause = p;
        incr  = i;
        mode  = md;
        count = 4'(cnt);
        modelEdge(cnt);
        @(posedge clk);
        #1;
        if (carry_out === 1'b1) saw_carry = 1'b1;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".digits"}, 32'(digits_hi), 32'(to_digits(ext_val, mode)));
        checkValue({tag, ".carry"},  32'(carry_out), 32'(m_carry));
        checkValue({tag, ".ovf"},    32'(ovf),       32'(m_ovf));
    endtask

    initial begin
        logic [4*(NUM_HI+1)-1:0] shown;
        int  guard;
        int  top;
        int  cnt;
        int  slot;
        bit  dir;
        bit  c;
        bit  p;

        rst_n   = 1'b0;
        clear   = 1'b0;
        pause   = 1'b0;
        incr    = 1'b1;
        mode    = 1'b0;
        count   = 4'd0;
        ext_val = 0;
        m_ovf   = 1'b0;
        m_carry = 1'b0;
        saw_carry = 1'b0;

        #12;
        checkValue("reset.digits", 32'(digits_hi), 32'h0);
        checkValue("reset.carry",  32'(carry_out), 32'h0);
        checkValue("reset.ovf",    32'(ovf),       32'h0);
        checkValue("reset.an",     32'(an),        32'h0);
        checkValue("reset.seg",    32'(seg),       32'h0);
        rst_n = 1'b1;

        $display("[TB] hex up 16*16 steps");
        applyStimulus(1, 0, 1, 0, 0);
        checkOutput("hex_up.clear");
        saw_carry = 1'b0;
        for (int i = 0; i < 256; i++) begin
            applyStimulus(0, 0, 1, 0, i % 16);
            checkOutput("hex_up");
        end
        checkValue("hex_up.final",    32'(digits_hi), 32'h010);
        checkValue("hex_up.no_carry", 32'(saw_carry), 32'h0);

        $display("[TB] decimal full wrap");
        applyStimulus(1, 0, 1, 1, 0);
        for (int i = 0; i < 999; i++) begin
            applyStimulus(0, 0, 1, 1, 9);
        end
        checkValue("dec_wrap.preset", 32'(digits_hi), 32'h999);
        checkOutput("dec_wrap.preset");
        applyStimulus(0, 0, 1, 1, 9);
        checkValue("dec_wrap.digits", 32'(digits_hi), 32'h000);
        checkValue("dec_wrap.carry",  32'(carry_out), 32'h1);
        checkValue("dec_wrap.ovf",    32'(ovf),       32'h1);
        applyStimulus(0, 0, 1, 1, 3);
        checkValue("dec_wrap.pulse_end", 32'(carry_out), 32'h0);
        checkValue("dec_wrap.ovf_stick", 32'(ovf),       32'h1);

        $display("[TB] decimal borrow then clear");
        applyStimulus(1, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkValue("dec_borrow.digits", 32'(digits_hi), 32'h999);
        checkValue("dec_borrow.carry",  32'(carry_out), 32'h1);
        checkOutput("dec_borrow");
        applyStimulus(1, 0, 0, 1, 0);
        checkValue("dec_borrow.clr_digits", 32'(digits_hi), 32'h000);
        checkValue("dec_borrow.clr_ovf",    32'(ovf),       32'h0);

        $display("[TB] clear/pause priority");
        applyStimulus(0, 0, 1, 1, 9);
        checkValue("prio.setup", 32'(digits_hi), 32'h001);
        applyStimulus(1, 1, 1, 1, 9);
        checkValue("prio.clear_wins", 32'(digits_hi), 32'h000);
        checkOutput("prio.clear_wins");
        applyStimulus(0, 0, 1, 1, 9);
        applyStimulus(0, 1, 1, 1, 9);
        checkValue("prio.pause_hold",  32'(digits_hi), 32'h001);
        checkValue("prio.pause_carry", 32'(carry_out), 32'h0);

        $display("[TB] mode switch with out-of-range digit");
        applyStimulus(1, 0, 1, 0, 0);
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 1, 0, 15);
        checkValue("mode_sw.hex_c", 32'(digits_hi), 32'h00C);
        applyStimulus(0, 0, 1, 1, 9);
        checkValue("mode_sw.up_fix", 32'(digits_hi), 32'h000);
        applyStimulus(1, 0, 1, 0, 0);
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 1, 0, 15);
        applyStimulus(0, 0, 0, 1, 0);
        checkValue("mode_sw.down_fix",   32'(digits_hi), 32'h009);
        checkValue("mode_sw.down_carry", 32'(carry_out), 32'h0);

        $display("[TB] random stimulus against model");
        for (int s = 0; s < 2; s++) begin
            applyStimulus(1, 0, 1, s[0], 0);
            checkOutput("rand.clear");
            top = s[0] ? 9 : 15;
            dir = 1'b1;
            for (int n = 0; n < 250; n++) begin
                if ($urandom_range(15, 0) == 0) dir = ~dir;
                p = ($urandom_range(7, 0) == 0);
                c = ($urandom_range(39, 0) == 0);
                if ($urandom_range(1, 0) == 1) cnt = dir ? top : 0;
                else                           cnt = int'($urandom_range(top, 0));
                applyStimulus(c, p, dir, s[0], cnt);
                checkOutput("rand");
            end
        end

        $display("[TB] scanner");
        #2;
        rst_n = 1'b0;
        ext_val = 0;
        m_ovf   = 1'b0;
        m_carry = 1'b0;
        #1;
        checkValue("scan.rst_an",     32'(an),        32'h0);
        checkValue("scan.rst_seg",    32'(seg),       32'h0);
        checkValue("scan.rst_digits", 32'(digits_hi), 32'h0);
        checkValue("scan.rst_ovf",    32'(ovf),       32'h0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < SCAN_DIV - 1; i++) begin
            applyStimulus(0, 1, 1, 1, 7);
            checkValue("scan.first_quiet", 32'(an), 32'h0);
        end
        applyStimulus(0, 1, 1, 1, 7);
        checkValue("scan.first_an",  32'(an),  32'h1);
        checkValue("scan.first_seg", 32'(seg), 32'(glyph(7, 1'b1)));

        for (int i = 0; i < 321; i++) applyStimulus(0, 0, 1, 1, 9);
        checkValue("scan.preset", 32'(digits_hi), 32'h321);
        checkOutput("scan.preset");

        guard = 0;
        while ((cyc % (SCAN_DIV * (NUM_HI + 1))) != 0 && guard < 64) begin
            applyStimulus(0, 1, 1, 1, 7);
            guard++;
        end

        shown = {12'h321, 4'h7};
        for (int s = 0; s < 2 * (NUM_HI + 1) + 1; s++) begin
            slot = s % (NUM_HI + 1);
            for (int i = 0; i < SCAN_DIV - 1; i++) applyStimulus(0, 1, 1, 1, 7);
            if (s == NUM_HI) begin
                checkValue("scan.hold_an", 32'(an), 32'(1 << (slot - 1)));
            end
            applyStimulus(0, 1, 1, 1, 7);
            checkValue("scan.an",  32'(an),  32'(1 << slot));
            checkValue("scan.seg", 32'(seg), 32'(glyph(int'(shown[4*slot +: 4]), 1'b1)));
        end

        for (int g = 0; g < NUM_HI * SCAN_DIV; g++) applyStimulus(0, 1, 1, 1, 7);
        for (int i = 0; i < SCAN_DIV; i++) applyStimulus(0, 1, 1, 1, 12);
        checkValue("scan.dec_blank_an",  32'(an),  32'h1);
        checkValue("scan.dec_blank_seg", 32'(seg), 32'(glyph(12, 1'b1)));
        for (int g = 0; g < NUM_HI * SCAN_DIV; g++) applyStimulus(0, 1, 1, 0, 7);
        for (int i = 0; i < SCAN_DIV; i++) applyStimulus(0, 1, 1, 0, 12);
        checkValue("scan.hex_c_an",  32'(an),  32'h1);
        checkValue("scan.hex_c_seg", 32'(seg), 32'(glyph(12, 1'b0)));

        for (int i = 0; i < 2; i++) applyStimulus(0, 1, 1, 1, 7);
        #2;
        rst_n = 1'b0;
        #1;
        checkValue("scan.midrst_an",     32'(an),        32'h0);
        checkValue("scan.midrst_seg",    32'(seg),       32'h0);
        checkValue("scan.midrst_digits", 32'(digits_hi), 32'h0);
        #2;
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
